imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Takes an instruction word, a format selector and a sideband tag through a valid/ready handshake. Returns the sign- or zero-extended immediate one cycle later. Covers all RV32/RV64 base immediate formats. A two-entry skid buffer keeps `in_ready` registered so decode-stage timing stays clean under backpressure.

---
 rtl/imm_gen_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined immediate generator for the decode stage. An instruction word
//   and a format selector are accepted through a valid/ready handshake. The
//   sign- or zero-extended immediate is returned one cycle later, together
//   with an unmodified sideband tag. An output register plus one skid register
//   hold up to two entries. This keeps in_ready a pure register output, with no
//   combinational path from out_ready.
//
//   Optional feature macro: IMM_GEN_FORMAT_CHECK_EN
//     defined   -> fmt_err flags an opcode that does not fit imm_type. The flag
//                  is captured on accept and travels with the entry.
//     undefined -> fmt_err is tied low and no check logic or storage exists.
//
// Parameters
//   DATA_WIDTH : immediate width, 32 or 64
//   INST_WIDTH : instruction width, fixed at 32
//   TAG_WIDTH  : sideband tag width
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   flush     in   synchronous flush, drops all held and incoming entries
//   in_valid  in   input word valid
//   in_ready  out  block can accept (registered)
//   inst      in   instruction word
//   imm_type  in   0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 6 CSR zimm, 7 NONE
//   in_tag    in   sideband tag
//   out_valid out  result valid
//   out_ready in   downstream accepts
//   imm       out  extended immediate
//   out_tag   out  tag belonging to imm
//   fmt_err   out  opcode/format mismatch flag
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic [2:0]            imm_type,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  fmt_err
);

    // ---------------------------------------------------------------- decode
    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] imm_new;
    logic                  shamt_hi;

    // The sixth shift-amount bit only exists for 64-bit shifts.
    assign shamt_hi = (DATA_WIDTH == 64) ? inst[25] : 1'b0;

    // Build a 32-bit sign-correct value first. The zero-extended formats
    // leave bit 31 clear, so one widening rule serves every format.
    always_comb begin
        imm32 = '0;
        case (imm_type)
            3'd0: imm32 = {{20{inst[31]}}, inst[31:20]};
            3'd1: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            3'd2: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            3'd3: imm32 = {inst[31:12], 12'b0};
            3'd4: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            3'd5: imm32 = {26'b0, shamt_hi, inst[24:20]};
            3'd6: imm32 = {27'b0, inst[19:15]};
            default: imm32 = '0;
        endcase
    end

    generate
        if (DATA_WIDTH == 64) begin : g_ext64
            assign imm_new = {{32{imm32[31]}}, imm32};
        end else begin : g_ext32
            assign imm_new = imm32[DATA_WIDTH-1:0];
        end
    endgenerate

    // --------------------------------------------------------------- control
    logic                  out_valid_q, out_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_WIDTH-1:0] out_imm_q, skid_imm_q;
    logic [TAG_WIDTH-1:0]  out_tag_q, skid_tag_q;
    logic                  accept;
    logic                  out_load_new, out_load_skid, skid_load_new;

    // A word presented together with flush is dropped.
    assign accept = in_valid && in_ready_q && !flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        out_load_new  = 1'b0;
        out_load_skid = 1'b0;
        skid_load_new = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // Older skid entry advances first. A new word takes its place.
                out_load_skid = 1'b1;
                out_valid_d   = 1'b1;
                skid_load_new = accept;
                skid_valid_d  = accept;
            end else begin
                out_load_new = accept;
                out_valid_d  = accept;
            end
        end else if (accept) begin
            skid_load_new = 1'b1;
            skid_valid_d  = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            if (out_load_skid) begin
                out_imm_q <= skid_imm_q;
                out_tag_q <= skid_tag_q;
            end else if (out_load_new) begin
                out_imm_q <= imm_new;
                out_tag_q <= in_tag;
            end
            if (skid_load_new) begin
                skid_imm_q <= imm_new;
                skid_tag_q <= in_tag;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign imm       = out_imm_q;
    assign out_tag   = out_tag_q;

`ifdef IMM_GEN_FORMAT_CHECK_EN
    // ---------------------------------------------------------- format check
    logic [6:0] opcode;
    logic       err_new;
    logic       out_err_q, skid_err_q;

    assign opcode = inst[6:0];

    always_comb begin
        err_new = 1'b0;
        case (imm_type)
            3'd0: err_new = !(opcode inside {7'b0000011, 7'b0010011, 7'b0011011,
                                             7'b1100111, 7'b1110011});
            3'd1: err_new = (opcode != 7'b0100011);
            3'd2: err_new = (opcode != 7'b1100011);
            3'd3: err_new = !(opcode inside {7'b0110111, 7'b0010111});
            3'd4: err_new = (opcode != 7'b1101111);
            3'd5: err_new = !(opcode inside {7'b0010011, 7'b0011011});
            3'd6: err_new = (opcode != 7'b1110011);
            default: err_new = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err_q  <= 1'b0;
            skid_err_q <= 1'b0;
        end else begin
            if (out_load_skid) begin
                out_err_q <= skid_err_q;
            end else if (out_load_new) begin
                out_err_q <= err_new;
            end
            if (skid_load_new) begin
                skid_err_q <= err_new;
            end
        end
    end

    assign fmt_err = out_err_q;
`else
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];
    assign fmt_err       = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: a 64-bit and a 32-bit instance share one stimulus.
// Expected results are queued on accept and a monitor compares them on output.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic [2:0]  imm_type;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, fmt_err;
    logic [63:0] imm;
    logic [7:0]  out_tag;
    logic        in_ready32, out_valid32, fmt_err32;
    logic [31:0] imm32;
    logic [7:0]  out_tag32;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [63:0] e64;
        logic [31:0] e32;
        logic [7:0]  tag;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.DATA_WIDTH(64), .INST_WIDTH(32), .TAG_WIDTH(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .imm_type(imm_type), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .out_tag(out_tag), .fmt_err(fmt_err)
    );

    imm_gen_pipe #(.DATA_WIDTH(32), .INST_WIDTH(32), .TAG_WIDTH(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .imm_type(imm_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .out_tag(out_tag32), .fmt_err(fmt_err32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output_tag", {56'b0, out_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("imm64",      imm,             e.e64);
                chk("tag64",      {56'b0, out_tag}, {56'b0, e.tag});
                chk("fmt_err64",  {63'b0, fmt_err}, {63'b0, e.err});
                chk("valid32",    {63'b0, out_valid32}, 64'h1);
                chk("imm32",      {32'b0, imm32},   {32'b0, e.e32});
                chk("tag32",      {56'b0, out_tag32}, {56'b0, e.tag});
                chk("fmt_err32",  {63'b0, fmt_err32}, {63'b0, e.err});
                $display("out tag=0x%02h imm64=0x%016h imm32=0x%08h fmt_err=%0d",
                         out_tag, imm, imm32, fmt_err);
            end
        end
    end

    // Presents one word and waits (bounded) for it to be accepted.
    task automatic send(input logic [31:0] i, input logic [2:0] t, input logic [7:0] tg,
                        input logic [63:0] e64, input logic [31:0] e32, input logic eerr,
                        output int stalls);
        exp_t e;
        stalls   = 0;
        in_valid = 1'b1;
        inst     = i;
        imm_type = t;
        in_tag   = tg;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            stalls++;
            if (stalls > 50) begin
                chk("accept_timeout", 64'h0, 64'h1);
                in_valid = 1'b0;
                return;
            end
        end
        e.e64 = e64;
        e.e32 = e32;
        e.tag = tg;
`ifdef IMM_GEN_FORMAT_CHECK_EN
        e.err = eerr;
`else
        e.err = 1'b0;
`endif
        sb.push_back(e);
        $display("in  tag=0x%02h inst=0x%08h type=%0d", tg, i, t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int st;
        int total_stalls;
        int guard;

        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst      = '0;
        imm_type  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("rst_in_ready",  {63'b0, in_ready},  64'h1);
        chk("rst_imm",       imm,                64'h0);
        chk("rst_out_tag",   {56'b0, out_tag},   64'h0);
        chk("rst_fmt_err",   {63'b0, fmt_err},   64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // I format, plus one-cycle latency with an empty output register.
        send(32'hFFF00093, 3'd0, 8'hA1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st);
        @(negedge clk);
        chk("latency_valid", {63'b0, out_valid}, 64'h1);
        chk("latency_tag",   {56'b0, out_tag},   64'hA1);
        @(posedge clk);
        #1;

        // Back-to-back stream across all formats; no stalls expected.
        total_stalls = 0;
        send(32'hFE000EE3, 3'd2, 8'hB2, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0, st); total_stalls += st;
        send(32'h001000EF, 3'd4, 8'hB3, 64'h0000_0000_0000_0800, 32'h0000_0800, 1'b0, st); total_stalls += st;
        send(32'h800000B7, 3'd3, 8'hB4, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0, st); total_stalls += st;
        send(32'h03F00013, 3'd5, 8'hB5, 64'h0000_0000_0000_003F, 32'h0000_001F, 1'b0, st); total_stalls += st;
        send(32'h000F8073, 3'd6, 8'hB6, 64'h0000_0000_0000_001F, 32'h0000_001F, 1'b0, st); total_stalls += st;
        send(32'hFFFFFFFF, 3'd7, 8'hB7, 64'h0,                   32'h0,          1'b0, st); total_stalls += st;
        send(32'h80000023, 3'd1, 8'hB8, 64'hFFFF_FFFF_FFFF_F800, 32'hFFFF_F800, 1'b0, st); total_stalls += st;
        send(32'h00000013, 3'd1, 8'hB9, 64'h0,                   32'h0,          1'b1, st); total_stalls += st;
        send(32'h00000013, 3'd0, 8'hBA, 64'h0,                   32'h0,          1'b0, st); total_stalls += st;
        chk("stream_stalls", total_stalls, 64'h0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: two entries held, third is refused until drain.
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 8'h01, 64'h1, 32'h1, 1'b0, st);
        send(32'h00200093, 3'd0, 8'h02, 64'h2, 32'h2, 1'b0, st);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {63'b0, in_ready},  64'h0);
            chk("bp_valid",    {63'b0, out_valid}, 64'h1);
            chk("bp_hold_tag", {56'b0, out_tag},   64'h01);
            chk("bp_hold_imm", imm,                64'h1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h00300093, 3'd0, 8'h03, 64'h3, 32'h3, 1'b0, st);
        chk("bp_third_stalled", {63'b0, (st > 0)}, 64'h1);
        repeat (3) @(posedge clk);
        #1;

        // Flush with two entries held; the word presented alongside is dropped.
        out_ready = 1'b0;
        send(32'h01000093, 3'd0, 8'h10, 64'h10, 32'h10, 1'b0, st);
        send(32'h01100093, 3'd0, 8'h11, 64'h11, 32'h11, 1'b0, st);
        flush    = 1'b1;
        in_valid = 1'b1;
        inst     = 32'h01200093;
        imm_type = 3'd0;
        in_tag   = 8'h12;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", {63'b0, out_valid}, 64'h0);
        chk("flush_in_ready",  {63'b0, in_ready},  64'h1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Asynchronous reset with an entry held.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'hFFF00093, 3'd0, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("arst_in_ready",  {63'b0, in_ready},  64'h1);
        chk("arst_imm",       imm,                64'h0);
        chk("arst_out_tag",   {56'b0, out_tag},   64'h0);
        chk("arst_fmt_err",   {63'b0, fmt_err},   64'h0);
        chk("arst_valid32",   {63'b0, out_valid32}, 64'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h000F8073, 3'd6, 8'h30, 64'h1F, 32'h1F, 1'b0, st);

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_left", sb.size(), 64'h0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
